// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush controller for the 5-stage pipeline. Detects
//               load-use hazards and taken-branch redirects, sequences
//               multi-cycle data-RAM accesses through a wait FSM with a
//               timeout fault, and keeps a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int unsigned RAM_TIMEOUT = 15,      // legal range 1..255
  parameter logic [1:0]  WSEL_RAM    = 2'b01,   // rf_wsel code for a load
  parameter int unsigned CNT_W       = 16       // stall counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // ID-stage operand usage
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_re1_i,
  input  logic             id_re2_i,
  // EX-stage writeback and redirect
  input  logic [4:0]       ex_wR_i,
  input  logic             ex_rf_we_i,
  input  logic [1:0]       ex_rf_wsel_i,
  input  logic             ex_br_taken_i,
  // MEM-stage data RAM handshake
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  // Stage-register controls
  output logic             pc_pause_o,
  output logic             ifid_pause_o,
  output logic             idex_pause_o,
  output logic             exmem_pause_o,
  output logic             memwb_flush_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  // Status
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Last wait_cnt value before the access is declared lost.
  localparam logic [7:0]       c_WAIT_LAST = 8'(RAM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_lu;
  logic             w_mw;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_pc_pause;
  logic             w_ifid_pause;
  logic             w_idex_pause;
  logic             w_exmem_pause;
  logic             w_memwb_flush;
  logic             w_ifid_flush;
  logic             w_idex_flush;

  // Hazard terms: a load in EX feeding a register actually read in ID, and
  // an outstanding RAM access (meaningless once faulted).
  always_comb begin
    w_rs1_hit = id_re1_i & (id_rs1_i == ex_wR_i);
    w_rs2_hit = id_re2_i & (id_rs2_i == ex_wR_i);
    w_lu      = ex_rf_we_i & (ex_rf_wsel_i == WSEL_RAM) & (ex_wR_i != 5'd0)
                & (w_rs1_hit | w_rs2_hit);
    w_mw      = mem_req_i & ~mem_ack_i & (r_state != ST_FAULT);
  end

  // Prioritised pause/flush decode; a RAM wait freezes the whole pipe so any
  // concurrent branch or load-use is replayed once the access completes.
  always_comb begin
    w_pc_pause    = 1'b0;
    w_ifid_pause  = 1'b0;
    w_idex_pause  = 1'b0;
    w_exmem_pause = 1'b0;
    w_memwb_flush = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    if (rst_i) begin
      // everything held low while in reset
    end else if (r_state == ST_FAULT) begin
      w_pc_pause    = 1'b1;
      w_ifid_pause  = 1'b1;
      w_idex_pause  = 1'b1;
      w_exmem_pause = 1'b1;
    end else if (w_mw) begin
      w_pc_pause    = 1'b1;
      w_ifid_pause  = 1'b1;
      w_idex_pause  = 1'b1;
      w_exmem_pause = 1'b1;
      w_memwb_flush = 1'b1;
    end else if (ex_br_taken_i) begin
      // the ID instruction is squashed, so a load-use on it is moot
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
    end else if (w_lu) begin
      w_pc_pause    = 1'b1;
      w_ifid_pause  = 1'b1;
      w_idex_flush  = 1'b1;
    end
  end

  // RAM wait FSM with timeout; a dropped request ends the wait like an ack,
  // and an ack in the timeout cycle still wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mw) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i || !mem_req_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state    <= ST_FAULT;
            r_err      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_FAULT: begin
          // only reset leaves FAULT
          r_state <= ST_FAULT;
          r_err   <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_pc_pause && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign pc_pause_o    = w_pc_pause;
  assign ifid_pause_o  = w_ifid_pause;
  assign idex_pause_o  = w_idex_pause;
  assign exmem_pause_o = w_exmem_pause;
  assign memwb_flush_o = w_memwb_flush;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_flush_o  = w_idex_flush;
  assign state_o       = r_state;
  assign err_o         = r_err;
  assign stall_cnt_o   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector bench for pipe_hazard_ctrl with a scoreboard
//               queue; the driver pushes hand-computed expectations and a
//               monitor compares them against the DUT each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int unsigned c_TIMEOUT = 4;
  localparam int unsigned c_CNT_W   = 4;

  // ctl vector order: {pc, ifid, idex, exmem pause, memwb, ifid, idex flush}
  localparam logic [6:0] c_NONE = 7'b0000000;
  localparam logic [6:0] c_LU   = 7'b1100001;
  localparam logic [6:0] c_BR   = 7'b0000011;
  localparam logic [6:0] c_MW   = 7'b1111100;
  localparam logic [6:0] c_FLT  = 7'b1111000;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [4:0]         id_rs1_i, id_rs2_i, ex_wR_i;
  logic               id_re1_i, id_re2_i, ex_rf_we_i, ex_br_taken_i;
  logic [1:0]         ex_rf_wsel_i;
  logic               mem_req_i, mem_ack_i;
  logic               pc_pause_o, ifid_pause_o, idex_pause_o, exmem_pause_o;
  logic               memwb_flush_o, ifid_flush_o, idex_flush_o;
  logic [1:0]         state_o;
  logic               err_o;
  logic [c_CNT_W-1:0] stall_cnt_o;

  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pipe_hazard_ctrl #(
    .RAM_TIMEOUT (c_TIMEOUT),
    .WSEL_RAM    (2'b01),
    .CNT_W       (c_CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_re1_i      (id_re1_i),
    .id_re2_i      (id_re2_i),
    .ex_wR_i       (ex_wR_i),
    .ex_rf_we_i    (ex_rf_we_i),
    .ex_rf_wsel_i  (ex_rf_wsel_i),
    .ex_br_taken_i (ex_br_taken_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .pc_pause_o    (pc_pause_o),
    .ifid_pause_o  (ifid_pause_o),
    .idex_pause_o  (idex_pause_o),
    .exmem_pause_o (exmem_pause_o),
    .memwb_flush_o (memwb_flush_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_flush_o  (idex_flush_o),
    .state_o       (state_o),
    .err_o         (err_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: one expectation consumed per cycle, sampled on the falling edge.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_pause_o, ifid_pause_o, idex_pause_o, exmem_pause_o,
               memwb_flush_o, ifid_flush_o, idex_flush_o};
        total++;
        if (act !== e.ctl || state_o !== e.st || err_o !== e.err ||
            stall_cnt_o !== e.cnt) begin
          bad++;
          $display("FAIL %s: actual ctl=%b state=%0d err=%b cnt=%0d, required ctl=%b state=%0d err=%b cnt=%0d",
                   e.name, act, state_o, err_o, stall_cnt_o,
                   e.ctl, e.st, e.err, e.cnt);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic re1, input logic re2, input logic [4:0] wr,
                     input logic we, input logic [1:0] wsel, input logic br,
                     input logic req, input logic ack);
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_re1_i      = re1;
    id_re2_i      = re2;
    ex_wR_i       = wr;
    ex_rf_we_i    = we;
    ex_rf_wsel_i  = wsel;
    ex_br_taken_i = br;
    mem_req_i     = req;
    mem_ack_i     = ack;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld_use(input logic br);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, br, 1'b0, 1'b0);
  endtask

  task automatic ram(input logic br, input logic req, input logic ack);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, br, req, ack);
  endtask

  // Queue the expectation for the current cycle, then move to the next one.
  task automatic chk(input string nm, input logic [6:0] ctl,
                     input logic [1:0] st, input logic err,
                     input logic [3:0] cnt);
    exp_t e;
    e.name = nm;
    e.ctl  = ctl;
    e.st   = st;
    e.err  = err;
    e.cnt  = cnt;
    q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int c;
    rst_i = 1'b1;
    ld_use(1'b0);
    @(posedge clk_i);
    #1;
    chk("reset_prio", c_NONE, 2'd0, 1'b0, 4'd0);
    rst_i = 1'b0;

    // load-use detection
    ld_use(1'b0);                                            chk("lu_rs1", c_LU, 2'd0, 1'b0, 4'd0);
    idle();                                                  chk("lu_clear", c_NONE, 2'd0, 1'b0, 4'd1);
    drv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
                                                             chk("lu_wr0", c_NONE, 2'd0, 1'b0, 4'd1);
    drv(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
                                                             chk("lu_re1_off", c_NONE, 2'd0, 1'b0, 4'd1);
    drv(5'd5, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
                                                             chk("lu_rs2", c_LU, 2'd0, 1'b0, 4'd1);
    drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
                                                             chk("alu_no_lu", c_NONE, 2'd0, 1'b0, 4'd2);

    // branch beats load-use
    ld_use(1'b1);                                            chk("br_over_lu", c_BR, 2'd0, 1'b0, 4'd2);
    idle();                                                  chk("br_after", c_NONE, 2'd0, 1'b0, 4'd2);

    // RAM wait, ack after 3 wait cycles
    ram(1'b0, 1'b1, 1'b0);                                   chk("ramw_c0", c_MW, 2'd0, 1'b0, 4'd2);
                                                             chk("ramw_c1", c_MW, 2'd1, 1'b0, 4'd3);
                                                             chk("ramw_c2", c_MW, 2'd1, 1'b0, 4'd4);
    ram(1'b0, 1'b1, 1'b1);                                   chk("ramw_ack", c_NONE, 2'd1, 1'b0, 4'd5);
    idle();                                                  chk("ramw_run", c_NONE, 2'd0, 1'b0, 4'd5);

    // ack in the first cycle: no stall
    ram(1'b0, 1'b1, 1'b1);                                   chk("ack_first", c_NONE, 2'd0, 1'b0, 4'd5);
    idle();                                                  chk("ack_first_run", c_NONE, 2'd0, 1'b0, 4'd5);

    // RAM wait with a branch held throughout
    ram(1'b1, 1'b1, 1'b0);                                   chk("brw_c0", c_MW, 2'd0, 1'b0, 4'd5);
                                                             chk("brw_c1", c_MW, 2'd1, 1'b0, 4'd6);
                                                             chk("brw_c2", c_MW, 2'd1, 1'b0, 4'd7);
    ram(1'b1, 1'b1, 1'b1);                                   chk("brw_ack", c_BR, 2'd1, 1'b0, 4'd8);
    idle();                                                  chk("brw_run", c_NONE, 2'd0, 1'b0, 4'd8);

    // request dropped mid-wait acts as ack
    ram(1'b0, 1'b1, 1'b0);                                   chk("drop_c0", c_MW, 2'd0, 1'b0, 4'd8);
    ram(1'b0, 1'b0, 1'b0);                                   chk("drop_c1", c_NONE, 2'd1, 1'b0, 4'd9);
    idle();                                                  chk("drop_run", c_NONE, 2'd0, 1'b0, 4'd9);

    // ack exactly in the timeout cycle wins
    ram(1'b0, 1'b1, 1'b0);                                   chk("ack4_c0", c_MW, 2'd0, 1'b0, 4'd9);
                                                             chk("ack4_w0", c_MW, 2'd1, 1'b0, 4'd10);
                                                             chk("ack4_w1", c_MW, 2'd1, 1'b0, 4'd11);
                                                             chk("ack4_w2", c_MW, 2'd1, 1'b0, 4'd12);
    ram(1'b0, 1'b1, 1'b1);                                   chk("ack4_w3", c_NONE, 2'd1, 1'b0, 4'd13);
    idle();                                                  chk("ack4_run", c_NONE, 2'd0, 1'b0, 4'd13);

    // back-to-back load-use stalls run the counter into saturation
    ld_use(1'b0);                                            chk("sat_a", c_LU, 2'd0, 1'b0, 4'd13);
                                                             chk("sat_b", c_LU, 2'd0, 1'b0, 4'd14);
                                                             chk("sat_c", c_LU, 2'd0, 1'b0, 4'd15);
                                                             chk("sat_d", c_LU, 2'd0, 1'b0, 4'd15);
    idle();                                                  chk("sat_hold", c_NONE, 2'd0, 1'b0, 4'd15);

    // reset pulse clears the counter
    rst_i = 1'b1;                                            chk("rst_pulse", c_NONE, 2'd0, 1'b0, 4'd0);
    rst_i = 1'b0;

    // timeout into FAULT, then 15 fault cycles (branch and a late ack ignored)
    ram(1'b0, 1'b1, 1'b0);                                   chk("to_c0", c_MW, 2'd0, 1'b0, 4'd0);
                                                             chk("to_w0", c_MW, 2'd1, 1'b0, 4'd1);
                                                             chk("to_w1", c_MW, 2'd1, 1'b0, 4'd2);
                                                             chk("to_w2", c_MW, 2'd1, 1'b0, 4'd3);
                                                             chk("to_w3", c_MW, 2'd1, 1'b0, 4'd4);
    for (int k = 0; k < 15; k++) begin
      c = 5 + k;
      if (c > 15) c = 15;
      ram(1'b1, 1'b1, (k == 7));
      chk("fault", c_FLT, 2'd2, 1'b1, 4'(c));
    end

    // asynchronous reset while in FAULT
    rst_i = 1'b1;                                            chk("arst_fault", c_NONE, 2'd0, 1'b0, 4'd0);
    rst_i = 1'b0;
    idle();                                                  chk("arst_fault_run", c_NONE, 2'd0, 1'b0, 4'd0);

    // asynchronous reset in MEM_WAIT, then a clean 3-cycle wait
    ram(1'b0, 1'b1, 1'b0);                                   chk("arw_c0", c_MW, 2'd0, 1'b0, 4'd0);
                                                             chk("arw_w0", c_MW, 2'd1, 1'b0, 4'd1);
    rst_i = 1'b1;                                            chk("arst_wait", c_NONE, 2'd0, 1'b0, 4'd0);
    rst_i = 1'b0;
    idle();                                                  chk("arst_wait_run", c_NONE, 2'd0, 1'b0, 4'd0);
    ram(1'b0, 1'b1, 1'b0);                                   chk("post_c0", c_MW, 2'd0, 1'b0, 4'd0);
                                                             chk("post_w0", c_MW, 2'd1, 1'b0, 4'd1);
                                                             chk("post_w1", c_MW, 2'd1, 1'b0, 4'd2);
    ram(1'b0, 1'b1, 1'b1);                                   chk("post_ack", c_NONE, 2'd1, 1'b0, 4'd3);
    idle();                                                  chk("post_run", c_NONE, 2'd0, 1'b0, 4'd3);

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: actual pending=%0d, required pending=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the pause inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus their flush (bubble) controls. It detects load-use hazards and taken-branch redirects, and sequences multi-cycle data-RAM accesses through a wait FSM with timeout. It also keeps a saturating stall-cycle performance counter.

## Interface
- RAM_TIMEOUT, 15: maximum MEM_WAIT cycles before fault; legal range 1..255.
- WSEL_RAM, 2'b01: rf_wsel encoding that marks a load (writeback from RAM).
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs1_i  in  5  ID-stage source register 1.
- id_rs2_i  in  5  ID-stage source register 2.
- id_re1_i  in  1  rs1 is actually read.
- id_re2_i  in  1  rs2 is actually read.
- ex_wR_i  in  5  destination register of the instruction in EX.
- ex_rf_we_i  in  1  EX instruction writes the register file.
- ex_rf_wsel_i  in  2  EX writeback select.
- ex_br_taken_i  in  1  EX resolves a taken branch or jump (redirect).
- mem_req_i  in  1  MEM-stage instruction accesses data RAM.
- mem_ack_i  in  1  data RAM completes the access this cycle.
- pc_pause_o  out  1  hold the PC.
- ifid_pause_o  out  1  hold IF/ID.
- idex_pause_o  out  1  hold ID/EX.
- exmem_pause_o  out  1  hold EX/MEM.
- memwb_flush_o  out  1  load a bubble into MEM/WB.
- ifid_flush_o  out  1  load a bubble into IF/ID.
- idex_flush_o  out  1  load a bubble into ID/EX.
- state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FAULT.
- err_o  out  1  sticky RAM-timeout fault.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_pause_o=1.

## Operation
- The hazard terms are combinational:
  - lu = ex_rf_we_i & (ex_rf_wsel_i==WSEL_RAM) & (ex_wR_i!=0) & ((id_re1_i & id_rs1_i==ex_wR_i) | (id_re2_i & id_rs2_i==ex_wR_i)).
  - mw = mem_req_i & ~mem_ack_i, valid in RUN or MEM_WAIT.
- Output priority, highest first:
  1. rst_i=1: all pause and flush outputs are 0.
  2. FAULT: pc, ifid, idex and exmem pauses are 1. All flushes are 0.
  3. mw: pc, ifid, idex and exmem pauses are 1; memwb_flush_o=1; ifid_flush_o=0 and idex_flush_o=0. A branch or load-use in the same cycle is held frozen and resolved after the wait.
  4. ex_br_taken_i: ifid_flush_o=1 and idex_flush_o=1, no pauses. lu is ignored because the ID instruction is squashed.
  5. lu: pc_pause_o=1, ifid_pause_o=1 and idex_flush_o=1. This inserts one bubble. lu clears on its own next cycle because the load has moved to MEM.
  6. Otherwise all outputs are 0.
- FSM:
  - RUN -> MEM_WAIT when mw.
  - MEM_WAIT -> RUN on mem_ack_i.
  - MEM_WAIT -> FAULT when wait_cnt==RAM_TIMEOUT-1 and ~mem_ack_i.
  - FAULT exits only on reset.
- If ack and timeout occur in the same cycle, ack wins and the FSM returns to RUN.
- wait_cnt is 8 bits. It clears on entry to MEM_WAIT, increments each MEM_WAIT cycle without ack, and clears on return to RUN.
- mem_req_i dropping while in MEM_WAIT is treated as ack, and the FSM returns to RUN.
- err_o=1 exactly while in FAULT.
- stall_cnt_o increments each cycle pc_pause_o=1. It holds at 2^CNT_W-1 and never wraps.

## Timing
- Pause and flush outputs are combinational from the current state and inputs, with zero-cycle latency. The stage registers sample them on the same edge.
- State, wait_cnt, err_o and stall_cnt_o are registered and update on the rising edge.
- Reset values:
  - state_o=0 (RUN), err_o=0, stall_cnt_o=0, wait_cnt=0.
  - Combinational outputs are 0 while rst_i=1.
- Reset asserted mid-MEM_WAIT or in FAULT returns the block to RUN immediately, asynchronously.
- A RAM access acked in its first cycle (mem_req_i & mem_ack_i in RUN) causes no stall and no state change.
- An access acked after N wait cycles stalls exactly N cycles.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots with no stall.

## Test plan
- Load-use: EX has ex_rf_we_i=1, wsel=2'b01, wR=5; ID has rs1=5 with re1=1.
  - Required: pc_pause_o=1, ifid_pause_o=1, idex_flush_o=1 for 1 cycle; stall_cnt_o goes 0->1.
  - Repeat with wR=0, or with re1=0: no stall.
- Branch with simultaneous load-use: ex_br_taken_i=1 with the lu conditions true.
  - Required: ifid_flush_o=1 and idex_flush_o=1, no pauses, stall_cnt_o unchanged.
- RAM wait: mem_req_i=1 with ack delayed 3 cycles.
  - Required: all four pauses and memwb_flush_o high for 3 cycles; state_o sequence 0,1,1,1,0; stall_cnt_o=3.
  - Repeat with ex_br_taken_i=1 throughout: flushes stay 0 during the wait and assert only in the ack cycle.
- Timeout: RAM_TIMEOUT=4, mem_req_i=1, no ack.
  - Required: FAULT after 4 MEM_WAIT cycles; err_o=1; pauses stuck high; rst_i pulse gives state_o=0 and err_o=0.
  - Repeat with ack exactly on the 4th cycle: returns to RUN, no fault.
- Saturation: CNT_W=4 with 20 consecutive stall cycles.
  - Required: stall_cnt_o stops at 15.
- Async reset mid-wait: rst_i asserted between clock edges in MEM_WAIT.
  - Required: state_o=0, wait_cnt cleared and all outputs 0 without waiting for an edge.
